// File: rtl/peak_track_arbiter.sv
// peak_track_arbiter: round-robin arbiter sharing one running-maximum datapath
// between NUM_REQ requesters. Each job is BATCH_LEN serial samples; the peak
// and the owning requester ID are returned on a valid/ready result channel.
// Optional build macro PEAK_TRACK_INDEX_EN adds res_idx, the 0-based beat
// index of the first occurrence of the peak.
module peak_track_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BATCH_LEN = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_max,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy
`ifdef PEAK_TRACK_INDEX_EN
    ,
    output logic [$clog2(BATCH_LEN)-1:0] res_idx
`endif
);

    localparam int unsigned CNT_W = $clog2(BATCH_LEN + 1);
`ifdef PEAK_TRACK_INDEX_EN
    localparam int unsigned IDX_W = $clog2(BATCH_LEN);
`endif

    typedef enum logic [1:0] {StIdle, StAccum, StResult} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
`ifdef PEAK_TRACK_INDEX_EN
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  res_idx_q, res_idx_d;
`endif

    logic [ID_W-1:0]   sel_id;
    logic              gnt_valid;
    logic [DATA_W-1:0] gnt_sample;

    // Round-robin pick: first valid lane after rr_q; the lowest offset wins
    // because it is assigned last.
    always_comb begin
        sel_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && ((int'(rr_q) + k) % int'(NUM_REQ)) == i) begin
                    sel_id = ID_W'(i);
                end
            end
        end
    end

    // Mux the granted lane's valid and sample into the shared datapath.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_sample = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                gnt_valid  = req_valid[i];
                gnt_sample = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready and busy are decoded straight from the state register and grant.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == StAccum) && (grant_q == ID_W'(i));
        end
        busy = (state_q != StIdle);
    end

    // Next-state logic: arbitrate, accumulate the running max, hold the result.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_max_d   = res_max_q;
        res_id_d    = res_id_q;
`ifdef PEAK_TRACK_INDEX_EN
        idx_d       = idx_q;
        res_idx_d   = res_idx_q;
`endif
        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    grant_d = sel_id;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef PEAK_TRACK_INDEX_EN
                    idx_d   = '0;
`endif
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (gnt_valid) begin
                    // Strict compare: ties keep the earlier beat as the peak.
                    if (gnt_sample > acc_q) begin
                        acc_d = gnt_sample;
`ifdef PEAK_TRACK_INDEX_EN
                        idx_d = IDX_W'(cnt_q);
`endif
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BATCH_LEN - 1)) begin
                        // Result includes the final beat just compared.
                        res_valid_d = 1'b1;
                        res_max_d   = acc_d;
                        res_id_d    = grant_q;
`ifdef PEAK_TRACK_INDEX_EN
                        res_idx_d   = idx_d;
`endif
                        state_d     = StResult;
                    end
                end
            end
            StResult: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_d        = grant_q;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= ID_W'(NUM_REQ - 1);
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_max_q   <= '0;
            res_id_q    <= '0;
`ifdef PEAK_TRACK_INDEX_EN
            idx_q       <= '0;
            res_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_max_q   <= res_max_d;
            res_id_q    <= res_id_d;
`ifdef PEAK_TRACK_INDEX_EN
            idx_q       <= idx_d;
            res_idx_q   <= res_idx_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_max   = res_max_q;
    assign res_id    = res_id_q;
`ifdef PEAK_TRACK_INDEX_EN
    assign res_idx   = res_idx_q;
`endif

endmodule

// File: tb/tb_peak_track_arbiter.sv
// Bench for peak_track_arbiter: directed scenarios with random sample data,
// checked against per-job peaks computed by plain arithmetic.
module tb_peak_track_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_max;
    logic [IW-1:0]     res_id;
    logic              busy;
`ifdef PEAK_TRACK_INDEX_EN
    logic [1:0]        res_idx;
`endif

    peak_track_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .BATCH_LEN (BL),
        .ID_W      (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_max   (res_max),
        .res_id    (res_id),
        .busy      (busy)
`ifdef PEAK_TRACK_INDEX_EN
        ,
        .res_idx   (res_idx)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int lane_q [NR][$];
    int exp_max [NR][$];
    int exp_idx [NR][$];
    int exp_ids [$];
    int beats [NR];
    int stall [NR];
    int stall_after [NR];
    int stall_len [NR];
    int rise_cyc;
    int c0;
    logic rv_prev;
    logic rand_rr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue a job on a lane and record its expected peak and first peak index.
    task automatic add_job(input int lane, input int s0, input int s1, input int s2,
                           input int s3);
        int s [4];
        int mx;
        int ix;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        mx = 0;
        for (int i = 0; i < BL; i++) if (s[i] > mx) mx = s[i];
        ix = 0;
        for (int i = BL - 1; i >= 0; i--) if (s[i] == mx) ix = i;
        for (int i = 0; i < BL; i++) lane_q[lane].push_back(s[i]);
        exp_max[lane].push_back(mx);
        exp_idx[lane].push_back(ix);
    endtask

    task automatic add_rand_job(input int lane);
        add_job(lane, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (lane_q[i].size() > 0) && (stall[i] == 0);
            if (lane_q[i].size() > 0) req_data[i*DW +: DW] = DW'(lane_q[i][0]);
            else req_data[i*DW +: DW] = '0;
        end
        if (rand_rr) res_ready = 1'($urandom_range(0, 1));
    endtask

    // One cycle: observe at negedge, advance lane queues just after posedge.
    task automatic step();
        logic [NR-1:0] fire;
        logic rfire;
        int id;
        @(negedge clk);
        chk("ready_onehot", 32'($onehot0(req_ready)), 1);
        if (exp_ids.size() > 0)
            chk("ready_lane", 32'(req_ready & ~(NR'(1) << exp_ids[0])), 0);
        if (res_valid && !rv_prev) rise_cyc = cyc;
        rv_prev = res_valid;
        fire = req_valid & req_ready;
        rfire = res_valid & res_ready;
        if (rfire) begin
            if (exp_ids.size() == 0) begin
                chk("unexpected_result", 32'(exp_ids.size()), 1);
            end else begin
                id = exp_ids.pop_front();
                chk("res_id", 32'(res_id), 32'(id));
                chk("res_max", 32'(res_max), 32'(exp_max[id].pop_front()));
`ifdef PEAK_TRACK_INDEX_EN
                chk("res_idx", 32'(res_idx), 32'(exp_idx[id].pop_front()));
`else
                void'(exp_idx[id].pop_front());
`endif
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (stall[i] > 0) stall[i]--;
            if (fire[i]) begin
                void'(lane_q[i].pop_front());
                beats[i]++;
                if (beats[i] == stall_after[i]) stall[i] = stall_len[i];
            end
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_ids.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(exp_ids.size()), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv_prev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        res_ready = 1'b0;
        rand_rr = 1'b0;
        rv_prev = 1'b0;
        for (int i = 0; i < NR; i++) begin
            beats[i] = 0; stall[i] = 0; stall_after[i] = 0; stall_len[i] = 0;
        end

        // Reset state.
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_max", 32'(res_max), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
`ifdef PEAK_TRACK_INDEX_EN
        chk("rst_res_idx", 32'(res_idx), 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, 3 9 9 5.
        res_ready = 1'b1;
        add_job(0, 3, 9, 9, 5);
        exp_ids.push_back(0);
        c0 = cyc;
        drive();
        drain(30);
        chk("single_latency", 32'(rise_cyc - c0), 5);

        // Round-robin with all lanes continuously valid, random backpressure.
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int l = 0; l < NR; l++) begin
                add_rand_job(l);
                exp_ids.push_back(l);
            end
        rand_rr = 1'b1;
        drive();
        drain(400);
        rand_rr = 1'b0;
        res_ready = 1'b1;
        drive();

        // Stall of the granted lane for 3 cycles after 2 beats (rr now at 3).
        for (int i = 0; i < NR; i++) beats[i] = 0;
        stall_after[0] = 2;
        stall_len[0] = 3;
        add_rand_job(0);
        exp_ids.push_back(0);
        c0 = cyc;
        drive();
        drain(40);
        chk("stall_latency", 32'(rise_cyc - c0), 8);
        stall_after[0] = 0;

        // Result backpressure with another lane waiting.
        res_ready = 1'b0;
        add_rand_job(1);
        add_rand_job(2);
        exp_ids.push_back(1);
        exp_ids.push_back(2);
        drive();
        for (int n = 0; n < 20 && !res_valid; n++) step();
        chk("bp_rise", 32'(res_valid), 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_max", 32'(res_max), 32'(exp_max[1][0]));
            chk("bp_id", 32'(res_id), 1);
            chk("bp_no_grant", 32'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        drive();
        drain(60);

        // All-zero job, then a maximal job (rr now at 2).
        add_job(3, 0, 0, 0, 0);
        exp_ids.push_back(3);
        drive();
        drain(30);
        add_job(0, 255, 1, 255, 0);
        exp_ids.push_back(0);
        drive();
        drain(30);

        // Reset after 2 accepted beats.
        for (int i = 0; i < NR; i++) beats[i] = 0;
        add_rand_job(3);
        exp_ids.push_back(3);
        drive();
        for (int n = 0; n < 20 && beats[3] < 2; n++) step();
        chk("mid_beats", 32'(beats[3]), 2);
        reset = 1'b1;
        #1;
        chk("mid_res_valid", 32'(res_valid), 0);
        chk("mid_res_max", 32'(res_max), 0);
        chk("mid_res_id", 32'(res_id), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_req_ready", 32'(req_ready), 0);
`ifdef PEAK_TRACK_INDEX_EN
        chk("mid_res_idx", 32'(res_idx), 0);
`endif
        lane_q[3].delete();
        exp_max[3].delete();
        exp_idx[3].delete();
        exp_ids.delete();
        rv_prev = 1'b0;
        drive();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) step();
        chk("post_rst_idle_valid", 32'(res_valid), 0);
        add_rand_job(2);
        add_rand_job(0);
        exp_ids.push_back(0);
        exp_ids.push_back(2);
        drive();
        drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
